// File: rtl/layerio_bank_sequencer_if.sv
// Handshake bundle between the layer sequencer (master) and the layer-IO bank sequencer (slave).
interface layerio_bank_sequencer_if #(
  parameter int unsigned NUM_BANKS = 3,
  parameter int unsigned LAYER_W   = 16
);
  localparam int unsigned SEL_W = $clog2(NUM_BANKS);

  logic                 start;
  logic [LAYER_W-1:0]   num_layers;
  logic [NUM_BANKS-1:0] wr_done;
  logic                 rd_done;
  logic [SEL_W-1:0]     wrsel;
  logic [SEL_W-1:0]     rdsel;
  logic [NUM_BANKS-1:0] soft_reset;
  logic                 wrote_layer;
  logic                 wrote_inference;
  logic [LAYER_W-1:0]   layer_idx;
  logic                 busy;
  logic                 err;

  modport master (
    output start, num_layers, wr_done, rd_done,
    input  wrsel, rdsel, soft_reset, wrote_layer, wrote_inference, layer_idx, busy, err
  );

  modport slave (
    input  start, num_layers, wr_done, rd_done,
    output wrsel, rdsel, soft_reset, wrote_layer, wrote_inference, layer_idx, busy, err
  );
endinterface

// File: rtl/layerio_bank_sequencer.sv
// Per-layer read/write bank rotation over NUM_BANKS layer-IO memories with soft-reset of released banks.
// Optional macro LAYERIO_INPUT_BANK_RESERVE_EN keeps INPUT_BANK out of the rotation after layer 0.
module layerio_bank_sequencer #(
  parameter int unsigned NUM_BANKS  = 3,
  parameter int unsigned INPUT_BANK = 0,
  parameter int unsigned LAYER_W    = 16
) (
  input  logic clk,
  input  logic reset,
  layerio_bank_sequencer_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(NUM_BANKS);

`ifdef LAYERIO_INPUT_BANK_RESERVE_EN
  if (NUM_BANKS < 3) begin : g_bank_count_check
    $error("layerio_bank_sequencer: NUM_BANKS must be >= 3 when the input bank is reserved");
  end
`else
  if (NUM_BANKS < 2) begin : g_bank_count_check
    $error("layerio_bank_sequencer: NUM_BANKS must be >= 2");
  end
`endif
  if (INPUT_BANK >= NUM_BANKS) begin : g_input_bank_check
    $error("layerio_bank_sequencer: INPUT_BANK out of range");
  end

  typedef enum logic {IDLE, RUN} state_t;

  // Successor bank in the rotation; skips the reserved input bank when enabled.
  function automatic logic [SEL_W-1:0] next_bank(input logic [SEL_W-1:0] b);
    int unsigned n;
    n = 32'(b) + 32'd1;
    if (n >= NUM_BANKS) n = 32'd0;
`ifdef LAYERIO_INPUT_BANK_RESERVE_EN
    if (n == INPUT_BANK) n = ((n + 32'd1) >= NUM_BANKS) ? 32'd0 : n + 32'd1;
`endif
    return SEL_W'(n);
  endfunction

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     rdsel_q, rdsel_d;
  logic [SEL_W-1:0]     wrsel_q, wrsel_d;
  logic [LAYER_W-1:0]   layer_idx_q, layer_idx_d;
  logic [LAYER_W-1:0]   num_layers_q, num_layers_d;
  logic                 wr_seen_q, wr_seen_d;
  logic                 rd_seen_q, rd_seen_d;
  logic [NUM_BANKS-1:0] soft_reset_q, soft_reset_d;
  logic                 wrote_layer_q, wrote_layer_d;
  logic                 wrote_inference_q, wrote_inference_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;

  logic [SEL_W-1:0]     rst_rdsel;
  logic [SEL_W-1:0]     rst_wrsel;
  logic [NUM_BANKS-1:0] wr_mask;
  logic [NUM_BANKS-1:0] rd_mask;
  logic                 wr_hit;
  logic                 wr_bad;

  assign rst_rdsel = SEL_W'(INPUT_BANK);
  assign rst_wrsel = next_bank(SEL_W'(INPUT_BANK));
  assign wr_mask   = NUM_BANKS'(1) << wrsel_q;
  assign rd_mask   = NUM_BANKS'(1) << rdsel_q;
  assign wr_hit    = |(bus.wr_done & wr_mask);
  assign wr_bad    = |(bus.wr_done & ~wr_mask);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      rdsel_q           <= rst_rdsel;
      wrsel_q           <= rst_wrsel;
      layer_idx_q       <= '0;
      num_layers_q      <= '0;
      wr_seen_q         <= 1'b0;
      rd_seen_q         <= 1'b0;
      soft_reset_q      <= '0;
      wrote_layer_q     <= 1'b0;
      wrote_inference_q <= 1'b0;
      busy_q            <= 1'b0;
      err_q             <= 1'b0;
    end else begin
      state_q           <= state_d;
      rdsel_q           <= rdsel_d;
      wrsel_q           <= wrsel_d;
      layer_idx_q       <= layer_idx_d;
      num_layers_q      <= num_layers_d;
      wr_seen_q         <= wr_seen_d;
      rd_seen_q         <= rd_seen_d;
      soft_reset_q      <= soft_reset_d;
      wrote_layer_q     <= wrote_layer_d;
      wrote_inference_q <= wrote_inference_d;
      busy_q            <= busy_d;
      err_q             <= err_d;
    end
  end

  // Next-state: completion tracking, bank advance and protocol error detection.
  always_comb begin
    state_d           = state_q;
    rdsel_d           = rdsel_q;
    wrsel_d           = wrsel_q;
    layer_idx_d       = layer_idx_q;
    num_layers_d      = num_layers_q;
    wr_seen_d         = wr_seen_q;
    rd_seen_d         = rd_seen_q;
    soft_reset_d      = '0;
    wrote_layer_d     = 1'b0;
    wrote_inference_d = 1'b0;
    busy_d            = busy_q;
    err_d             = err_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if ((|bus.wr_done) || bus.rd_done) err_d = 1'b1;
        if (bus.start) begin
          if (bus.num_layers != '0) begin
            num_layers_d = bus.num_layers;
            layer_idx_d  = '0;
            wr_seen_d    = 1'b0;
            rd_seen_d    = 1'b0;
            state_d      = RUN;
            busy_d       = 1'b1;
          end else begin
            wrote_inference_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (wr_bad || (wr_hit && wr_seen_q) || (bus.rd_done && rd_seen_q)) err_d = 1'b1;
        wr_seen_d = wr_seen_q | wr_hit;
        rd_seen_d = rd_seen_q | bus.rd_done;

        if (wr_seen_d && rd_seen_d) begin
          wr_seen_d     = 1'b0;
          rd_seen_d     = 1'b0;
          wrote_layer_d = 1'b1;
`ifdef LAYERIO_INPUT_BANK_RESERVE_EN
          if (rdsel_q != rst_rdsel) soft_reset_d = rd_mask;
`else
          soft_reset_d = rd_mask;
`endif
          if (layer_idx_q == (num_layers_q - LAYER_W'(1))) begin
            wrote_inference_d = 1'b1;
            state_d           = IDLE;
            busy_d            = 1'b0;
            rdsel_d           = rst_rdsel;
            wrsel_d           = rst_wrsel;
            layer_idx_d       = '0;
          end else begin
            rdsel_d     = wrsel_q;
            wrsel_d     = next_bank(wrsel_q);
            layer_idx_d = layer_idx_q + LAYER_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.rdsel           = rdsel_q;
  assign bus.wrsel           = wrsel_q;
  assign bus.layer_idx       = layer_idx_q;
  assign bus.soft_reset      = soft_reset_q;
  assign bus.wrote_layer     = wrote_layer_q;
  assign bus.wrote_inference = wrote_inference_q;
  assign bus.busy            = busy_q;
  assign bus.err             = err_q;
endmodule

// File: tb/tb_layerio_bank_sequencer.sv
// Directed self-checking bench for layerio_bank_sequencer (NUM_BANKS=3, INPUT_BANK=0).
module tb_layerio_bank_sequencer;
  localparam int unsigned NB = 3;
  localparam int unsigned LW = 16;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  layerio_bank_sequencer_if #(.NUM_BANKS(NB), .LAYER_W(LW)) bus ();

  layerio_bank_sequencer #(.NUM_BANKS(NB), .INPUT_BANK(0), .LAYER_W(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [NB-1:0] wr, input logic rd);
    bus.wr_done = wr;
    bus.rd_done = rd;
    tick();
    bus.wr_done = '0;
    bus.rd_done = 1'b0;
  endtask

  task automatic do_start(input logic [LW-1:0] n);
    bus.start      = 1'b1;
    bus.num_layers = n;
    tick();
    bus.start      = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (bus.rdsel !== 2'd0) begin errors++; $display("FAIL reset_rdsel: got %0d exp 0", bus.rdsel); end
    checks++; if (bus.wrsel !== 2'd1) begin errors++; $display("FAIL reset_wrsel: got %0d exp 1", bus.wrsel); end
    checks++; if (bus.layer_idx !== 16'd0) begin errors++; $display("FAIL reset_layer_idx: got %0d exp 0", bus.layer_idx); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b exp 0", bus.busy); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b exp 0", bus.err); end
    checks++; if (bus.soft_reset !== 3'b000) begin errors++; $display("FAIL reset_soft_reset: got %b exp 000", bus.soft_reset); end
    checks++; if ({bus.wrote_layer, bus.wrote_inference} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b exp 00", {bus.wrote_layer, bus.wrote_inference}); end
    reset = 1'b0;
  endtask

  // Four-layer inference, wr_done then rd_done three cycles later.
  task automatic test_rotation();
    logic [1:0]    er [0:4];
    logic [1:0]    ew [0:4];
    logic [NB-1:0] es [0:3];
`ifdef LAYERIO_INPUT_BANK_RESERVE_EN
    er = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd0};
    ew = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
    es = '{3'b000, 3'b010, 3'b100, 3'b010};
`else
    er = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
    ew = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd1};
    es = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif
    do_start(16'd4);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rot_busy_start: got %0b exp 1", bus.busy); end
    for (int i = 0; i < 4; i++) begin
      checks++; if ({bus.rdsel, bus.wrsel} !== {er[i], ew[i]}) begin errors++; $display("FAIL rot_sel_l%0d: got (%0d,%0d) exp (%0d,%0d)", i, bus.rdsel, bus.wrsel, er[i], ew[i]); end
      checks++; if (bus.layer_idx !== LW'(i)) begin errors++; $display("FAIL rot_layer_idx_l%0d: got %0d exp %0d", i, bus.layer_idx, i); end
      pulse(3'b001 << ew[i], 1'b0);
      checks++; if (bus.wrote_layer !== 1'b0) begin errors++; $display("FAIL rot_early_wl_l%0d: got %0b exp 0", i, bus.wrote_layer); end
      tick();
      tick();
      pulse('0, 1'b1);
      checks++; if (bus.wrote_layer !== 1'b1) begin errors++; $display("FAIL rot_wl_l%0d: got %0b exp 1", i, bus.wrote_layer); end
      checks++; if (bus.soft_reset !== es[i]) begin errors++; $display("FAIL rot_sr_l%0d: got %b exp %b", i, bus.soft_reset, es[i]); end
      checks++; if (bus.wrote_inference !== 1'(i == 3)) begin errors++; $display("FAIL rot_wi_l%0d: got %0b exp %0b", i, bus.wrote_inference, i == 3); end
      checks++; if ({bus.rdsel, bus.wrsel} !== {er[i+1], ew[i+1]}) begin errors++; $display("FAIL rot_next_sel_l%0d: got (%0d,%0d) exp (%0d,%0d)", i, bus.rdsel, bus.wrsel, er[i+1], ew[i+1]); end
      checks++; if (bus.busy !== 1'(i != 3)) begin errors++; $display("FAIL rot_busy_l%0d: got %0b exp %0b", i, bus.busy, i != 3); end
      tick();
      checks++; if ({bus.wrote_layer, bus.wrote_inference, bus.soft_reset} !== 5'b0) begin errors++; $display("FAIL rot_pulse_width_l%0d: got %b exp 00000", i, {bus.wrote_layer, bus.wrote_inference, bus.soft_reset}); end
    end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rot_err: got %0b exp 0", bus.err); end
  endtask

  // Coincident wr/rd pulses, plus start while running and on the last advance.
  task automatic test_simultaneous();
    logic [NB-1:0] sr0;
`ifdef LAYERIO_INPUT_BANK_RESERVE_EN
    sr0 = 3'b000;
`else
    sr0 = 3'b001;
`endif
    do_start(16'd2);
    bus.start      = 1'b1;
    bus.num_layers = 16'd0;
    pulse(3'b010, 1'b1);
    bus.start = 1'b0;
    checks++; if (bus.wrote_layer !== 1'b1) begin errors++; $display("FAIL sim_wl: got %0b exp 1", bus.wrote_layer); end
    checks++; if (bus.soft_reset !== sr0) begin errors++; $display("FAIL sim_sr: got %b exp %b", bus.soft_reset, sr0); end
    checks++; if ({bus.rdsel, bus.wrsel} !== {2'd1, 2'd2}) begin errors++; $display("FAIL sim_sel: got (%0d,%0d) exp (1,2)", bus.rdsel, bus.wrsel); end
    checks++; if ({bus.wrote_inference, bus.err} !== 2'b00) begin errors++; $display("FAIL sim_start_ignored: got %b exp 00", {bus.wrote_inference, bus.err}); end
    tick();
    checks++; if ({bus.wrote_layer, bus.soft_reset} !== 4'b0) begin errors++; $display("FAIL sim_width: got %b exp 0000", {bus.wrote_layer, bus.soft_reset}); end
    bus.start      = 1'b1;
    bus.num_layers = 16'd5;
    pulse(3'b100, 1'b1);
    bus.start = 1'b0;
    checks++; if ({bus.wrote_layer, bus.wrote_inference, bus.busy} !== 3'b110) begin errors++; $display("FAIL sim_last: got %b exp 110", {bus.wrote_layer, bus.wrote_inference, bus.busy}); end
    checks++; if (bus.soft_reset !== 3'b010) begin errors++; $display("FAIL sim_last_sr: got %b exp 010", bus.soft_reset); end
    tick();
    checks++; if ({bus.busy, bus.wrote_inference} !== 2'b00) begin errors++; $display("FAIL sim_no_restart: got %b exp 00", {bus.busy, bus.wrote_inference}); end
  endtask

  task automatic test_zero_layers();
    do_start(16'd0);
    checks++; if ({bus.wrote_inference, bus.wrote_layer, bus.busy} !== 3'b100) begin errors++; $display("FAIL zero_strobe: got %b exp 100", {bus.wrote_inference, bus.wrote_layer, bus.busy}); end
    tick();
    checks++; if ({bus.wrote_inference, bus.busy} !== 2'b00) begin errors++; $display("FAIL zero_after: got %b exp 00", {bus.wrote_inference, bus.busy}); end
  endtask

  task automatic test_errors();
    do_start(16'd1);
    pulse(3'b100, 1'b0);
    checks++; if ({bus.err, bus.wrote_layer} !== 2'b10) begin errors++; $display("FAIL err_wrong_bank: got %b exp 10", {bus.err, bus.wrote_layer}); end
    pulse('0, 1'b1);
    pulse('0, 1'b1);
    checks++; if ({bus.err, bus.wrote_layer, bus.busy} !== 3'b101) begin errors++; $display("FAIL err_no_advance: got %b exp 101", {bus.err, bus.wrote_layer, bus.busy}); end
    pulse(3'b010, 1'b0);
    checks++; if ({bus.wrote_layer, bus.wrote_inference, bus.err} !== 3'b111) begin errors++; $display("FAIL err_advance: got %b exp 111", {bus.wrote_layer, bus.wrote_inference, bus.err}); end
    tick();
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b exp 1", bus.err); end

    apply_reset();
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %0b exp 0", bus.err); end
    do_start(16'd2);
    pulse('0, 1'b1);
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL err_first_rd: got %0b exp 0", bus.err); end
    pulse('0, 1'b1);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_second_rd: got %0b exp 1", bus.err); end

    apply_reset();
    do_start(16'd2);
    pulse(3'b010, 1'b0);
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL err_first_wr: got %0b exp 0", bus.err); end
    pulse(3'b010, 1'b0);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_second_wr: got %0b exp 1", bus.err); end

    apply_reset();
    pulse('0, 1'b1);
    checks++; if ({bus.err, bus.busy} !== 2'b10) begin errors++; $display("FAIL err_idle_rd: got %b exp 10", {bus.err, bus.busy}); end
    apply_reset();
  endtask

  task automatic test_reset_mid_layer();
    do_start(16'd3);
    pulse(3'b010, 1'b1);
    pulse(3'b100, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({bus.rdsel, bus.wrsel} !== {2'd0, 2'd1}) begin errors++; $display("FAIL mid_sel: got (%0d,%0d) exp (0,1)", bus.rdsel, bus.wrsel); end
    checks++; if (bus.layer_idx !== 16'd0) begin errors++; $display("FAIL mid_layer_idx: got %0d exp 0", bus.layer_idx); end
    checks++; if ({bus.busy, bus.err, bus.wrote_layer, bus.wrote_inference, bus.soft_reset} !== 7'b0) begin errors++; $display("FAIL mid_outputs: got %b exp 0000000", {bus.busy, bus.err, bus.wrote_layer, bus.wrote_inference, bus.soft_reset}); end
    do_start(16'd1);
    pulse('0, 1'b1);
    checks++; if ({bus.wrote_layer, bus.wrote_inference, bus.busy} !== 3'b001) begin errors++; $display("FAIL mid_stale_wr: got %b exp 001", {bus.wrote_layer, bus.wrote_inference, bus.busy}); end
    pulse(3'b010, 1'b0);
    checks++; if ({bus.wrote_layer, bus.wrote_inference, bus.busy} !== 3'b110) begin errors++; $display("FAIL mid_fresh_done: got %b exp 110", {bus.wrote_layer, bus.wrote_inference, bus.busy}); end
  endtask

  initial begin
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.num_layers = '0;
    bus.wr_done    = '0;
    bus.rd_done    = 1'b0;
    test_reset();
    test_rotation();
    test_simultaneous();
    test_zero_layers();
    test_errors();
    test_reset_mid_layer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
